// File: rtl/mode6_sub_pipe.sv
// Multi-lane half-precision subtract pipeline: outp lane i = a_inp lane i - b.
// Global stall, per-beat subtrahend snapshot, saturating beat counter and sticky NaN flag.

module mode6_fp_sub #(
    parameter int MANTISSA        = 10,
    parameter int EXPONENT        = 5,
    parameter int IEEE_COMPLIANCE = 0
) (
    input  logic [MANTISSA+EXPONENT:0] a,
    input  logic [MANTISSA+EXPONENT:0] b,
    output logic [MANTISSA+EXPONENT:0] z
);
    localparam int DW = MANTISSA + EXPONENT + 1;
    localparam int SW = MANTISSA + 5;      // carry, hidden, mantissa, guard/round/sticky
    localparam int EW = EXPONENT + 2;
    localparam logic [EXPONENT-1:0] EMAX = '1;
    localparam logic [EXPONENT-1:0] SWL  = EXPONENT'(SW);
    localparam logic [DW-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MANTISSA-1){1'b0}}};

    logic                sa, sb, ha, hb;
    logic [EXPONENT-1:0] ea, eb, ea_eff, eb_eff, e_big, e_sml, diff;
    logic [MANTISSA-1:0] ma, mb, frac;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                swap, s_big, eff_sub, sticky, up;
    logic [SW-1:0]       big, sml, shifted, sum;
    logic [SW-2:0]       norm;
    logic [EW-1:0]       lz, e_res, e_fin;
    logic [MANTISSA+1:0] rnd;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    assign a_nan  = (ea == EMAX) && (ma != '0);
    assign b_nan  = (eb == EMAX) && (mb != '0);
    assign a_inf  = (ea == EMAX) && (ma == '0);
    assign b_inf  = (eb == EMAX) && (mb == '0);
    // Without IEEE compliance, subnormal operands are flushed to zero.
    assign a_zero = (ea == '0) && ((IEEE_COMPLIANCE == 0) || (ma == '0));
    assign b_zero = (eb == '0) && ((IEEE_COMPLIANCE == 0) || (mb == '0));
    assign ha     = (ea != '0);
    assign hb     = (eb != '0);
    assign ea_eff = (ea == '0) ? EXPONENT'(1) : ea;
    assign eb_eff = (eb == '0) ? EXPONENT'(1) : eb;
    assign eff_sub = (sa == sb);

    always_comb begin
        swap  = {eb, mb} > {ea, ma};
        e_big = swap ? eb_eff : ea_eff;
        e_sml = swap ? ea_eff : eb_eff;
        s_big = swap ? ~sb : sa;
        big   = {1'b0, swap ? hb : ha, swap ? mb : ma, 3'b000};
        sml   = {1'b0, swap ? ha : hb, swap ? ma : mb, 3'b000};
        diff  = e_big - e_sml;
        if (diff >= SWL) begin
            shifted = '0;
            sticky  = 1'b1;
        end else begin
            shifted = sml >> diff;
            sticky  = |(sml & ~({SW{1'b1}} << diff));
        end
        shifted[0] = shifted[0] | sticky;
        sum = eff_sub ? (big - shifted) : (big + shifted);

        lz = '0;
        for (int unsigned i = 0; i < SW - 1; i++) begin
            if (sum[i]) lz = EW'(SW - 2 - i);
        end
        if (sum[SW-1]) begin
            norm  = {sum[SW-1:2], sum[1] | sum[0]};
            e_res = {2'b00, e_big} + EW'(1);
        end else begin
            norm  = sum[SW-2:0] << lz;
            e_res = {2'b00, e_big} - lz;
        end

        up    = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd   = {1'b0, norm[SW-2:3]} + {{(MANTISSA+1){1'b0}}, up};
        e_fin = e_res + {{(EW-1){1'b0}}, rnd[MANTISSA+1]};
        frac  = rnd[MANTISSA+1] ? rnd[MANTISSA:1] : rnd[MANTISSA-1:0];

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) z = QNAN;
        else if (a_inf)                z = a;
        else if (b_inf)                z = {~sb, b[DW-2:0]};
        else if (a_zero && b_zero)     z = {sa & ~sb, {(DW-1){1'b0}}};
        else if (a_zero)               z = {~sb, b[DW-2:0]};
        else if (b_zero)               z = a;
        else if (sum == '0)            z = '0;
        else if (e_fin[EW-1] || (e_fin == '0)) z = {s_big, {(DW-1){1'b0}}};
        else if (e_fin >= {2'b00, EMAX})       z = {s_big, EMAX, {MANTISSA{1'b0}}};
        else                           z = {s_big, e_fin[EXPONENT-1:0], frac};
    end
endmodule

module mode6_sub_pipe #(
    parameter int NUM_LANES = 4,
    parameter int LATENCY   = 2,
    localparam int DATAWIDTH       = 16,
    localparam int MANTISSA        = 10,
    localparam int EXPONENT        = 5,
    localparam int IEEE_COMPLIANCE = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           b_load,
    input  logic [DATAWIDTH-1:0]           b_inp,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [NUM_LANES*DATAWIDTH-1:0] a_inp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*DATAWIDTH-1:0] outp,
    output logic                           out_last,
    output logic [15:0]                    beat_cnt,
    output logic                           nan_seen
);
    localparam int LW = NUM_LANES * DATAWIDTH;

    logic [DATAWIDTH-1:0] b_reg, b_snap, b_eff, sub_b;
    logic [LATENCY-1:0]   vld, lst, vin, lin;
    logic [LW-1:0]        dat [LATENCY];
    logic [LW-1:0]        din [LATENCY];
    logic [LW-1:0]        sub_a, sub_y;
    logic                 advance, accept, emit, nan_hit;

    assign out_valid = vld[LATENCY-1];
    assign out_last  = lst[LATENCY-1];
    assign outp      = dat[LATENCY-1];
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign accept    = in_valid & advance;
    assign emit      = out_valid & out_ready;
    // A beat accepted together with b_load uses the new subtrahend.
    assign b_eff     = b_load ? b_inp : b_reg;

    if (LATENCY == 1) begin : g_sub_first
        assign sub_a = a_inp;
        assign sub_b = b_eff;
    end else begin : g_sub_mid
        assign sub_a = dat[0];
        assign sub_b = b_snap;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mode6_fp_sub #(
            .MANTISSA        (MANTISSA),
            .EXPONENT        (EXPONENT),
            .IEEE_COMPLIANCE (IEEE_COMPLIANCE)
        ) u_sub (
            .a (sub_a[i*DATAWIDTH +: DATAWIDTH]),
            .b (sub_b),
            .z (sub_y[i*DATAWIDTH +: DATAWIDTH])
        );
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign vin[k] = in_valid;
            assign lin[k] = in_last;
            assign din[k] = (LATENCY == 1) ? sub_y : a_inp;
        end else begin : g_next
            assign vin[k] = vld[k-1];
            assign lin[k] = lst[k-1];
            assign din[k] = (k == 1) ? sub_y : dat[k-1];
        end
    end

    always_comb begin
        nan_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if ((&outp[i*DATAWIDTH + MANTISSA +: EXPONENT]) && (|outp[i*DATAWIDTH +: MANTISSA]))
                nan_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld      <= '0;
            lst      <= '0;
            b_reg    <= '0;
            b_snap   <= '0;
            beat_cnt <= '0;
            nan_seen <= 1'b0;
            for (int unsigned k = 0; k < LATENCY; k++) dat[k] <= '0;
        end else begin
            if (b_load) b_reg <= b_inp;
            if (advance) begin
                vld <= vin;
                lst <= lin;
                for (int unsigned k = 0; k < LATENCY; k++) dat[k] <= din[k];
                if (in_valid) b_snap <= b_eff;
            end
            if (b_load)                              beat_cnt <= accept ? 16'd1 : 16'd0;
            else if (accept && (beat_cnt != 16'hFFFF)) beat_cnt <= beat_cnt + 16'd1;
            if (emit && nan_hit) nan_seen <= 1'b1;
            else if (b_load)     nan_seen <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mode6_sub_pipe.sv
// Directed bench for mode6_sub_pipe across several lane/latency configurations.
`timescale 1ns/1ps
module tb_mode6_sub_pipe;
    localparam int NI   = 5;
    localparam int MAXW = 256;
    localparam int NL_T  [NI] = '{4, 1, 4, 16, 16};
    localparam int LAT_T [NI] = '{2, 1, 4, 1, 4};
    // 2..9 and the same values minus 1.0
    localparam logic [15:0] A_TAB [8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                          16'h4600, 16'h4700, 16'h4800, 16'h4880};
    localparam logic [15:0] R_TAB [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                          16'h4500, 16'h4600, 16'h4700, 16'h4800};

    logic          clk = 1'b0;
    logic          reset, b_load, in_last;
    logic [15:0]   b_inp;
    logic [15:0]   lane_val [16];
    logic [NI-1:0] in_valid, out_ready, in_ready, out_valid, out_last, nan_seen;
    logic [MAXW-1:0] outp_w [NI];
    logic [15:0]   beat_cnt [NI];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NL = NL_T[g];
        logic [NL*16-1:0] a_g, o_g;
        for (genvar l = 0; l < NL; l++) begin : g_a
            assign a_g[l*16 +: 16] = lane_val[l];
        end
        if (NL < 16) begin : g_pad
            assign outp_w[g] = {{(MAXW - NL*16){1'b0}}, o_g};
        end else begin : g_full
            assign outp_w[g] = o_g;
        end
        mode6_sub_pipe #(.NUM_LANES(NL), .LATENCY(LAT_T[g])) u_dut (
            .clk       (clk),
            .reset     (reset),
            .b_load    (b_load),
            .b_inp     (b_inp),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_last   (in_last),
            .a_inp     (a_g),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .outp      (o_g),
            .out_last  (out_last[g]),
            .beat_cnt  (beat_cnt[g]),
            .nan_seen  (nan_seen[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; b_load = 1'b0; in_valid = '0; out_ready = '1; in_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v);
        b_load = 1'b1; b_inp = v;
        tick();
        b_load = 1'b0;
    endtask

    task automatic test_reset(input int g);
        do_reset();
        checks++; if (out_valid[g] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b want 0", g, out_valid[g]); end
        checks++; if (out_last[g] !== 1'b0) begin errors++; $display("FAIL reset_out_last dut%0d: got %b want 0", g, out_last[g]); end
        checks++; if (in_ready[g] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b want 1", g, in_ready[g]); end
        checks++; if (beat_cnt[g] !== 16'd0) begin errors++; $display("FAIL reset_beat_cnt dut%0d: got %0d want 0", g, beat_cnt[g]); end
        checks++; if (nan_seen[g] !== 1'b0) begin errors++; $display("FAIL reset_nan_seen dut%0d: got %b want 0", g, nan_seen[g]); end
        checks++; if (outp_w[g] !== '0) begin errors++; $display("FAIL reset_outp dut%0d: got %h want 0", g, outp_w[g]); end
    endtask

    task automatic test_basic(input int g);
        logic [MAXW-1:0] exp_v;
        int k;
        do_reset();
        load_b(16'h3C00);
        for (int l = 0; l < 16; l++) lane_val[l] = 16'h4200;
        in_valid[g] = 1'b1;
        #1;
        checks++; if (in_ready[g] !== 1'b1) begin errors++; $display("FAIL basic_in_ready dut%0d: got %b want 1", g, in_ready[g]); end
        tick();
        in_valid[g] = 1'b0;
        checks++; if (beat_cnt[g] !== 16'd1) begin errors++; $display("FAIL basic_beat_cnt dut%0d: got %0d want 1", g, beat_cnt[g]); end
        k = 1;
        while (out_valid[g] !== 1'b1 && k < 12) begin tick(); k++; end
        checks++; if (k != LAT_T[g] || out_valid[g] !== 1'b1) begin errors++; $display("FAIL basic_latency dut%0d: got %0d cycles want %0d", g, k, LAT_T[g]); end
        exp_v = '0;
        for (int l = 0; l < NL_T[g]; l++) exp_v[l*16 +: 16] = 16'h4000;
        checks++; if (outp_w[g] !== exp_v) begin errors++; $display("FAIL basic_outp dut%0d: got %h want %h", g, outp_w[g], exp_v); end
        tick();
        checks++; if (out_valid[g] !== 1'b0) begin errors++; $display("FAIL basic_drain dut%0d: got %b want 0", g, out_valid[g]); end
    endtask

    task automatic test_backpressure(input int g);
        logic [MAXW-1:0] exp_v;
        int ni, no;
        logic acc, stall_seen;
        do_reset();
        load_b(16'h3C00);
        ni = 0; no = 0; stall_seen = 1'b0;
        for (int c = 0; c < 60 && no < 8; c++) begin
            out_ready[g] = !(c >= 4 && c < 9);
            in_valid[g]  = (ni < 8);
            in_last      = (ni == 7);
            for (int l = 0; l < 16; l++) lane_val[l] = A_TAB[(ni + l) % 8];
            #1;
            if (out_valid[g] && !out_ready[g]) stall_seen = 1'b1;
            checks++; if (in_ready[g] !== !(out_valid[g] && !out_ready[g])) begin errors++; $display("FAIL bp_in_ready dut%0d c%0d: got %b want %b", g, c, in_ready[g], !(out_valid[g] && !out_ready[g])); end
            acc = in_valid[g] && in_ready[g];
            if (out_valid[g] && out_ready[g]) begin
                exp_v = '0;
                for (int l = 0; l < NL_T[g]; l++) exp_v[l*16 +: 16] = R_TAB[(no + l) % 8];
                checks++; if (outp_w[g] !== exp_v) begin errors++; $display("FAIL bp_outp dut%0d beat%0d: got %h want %h", g, no, outp_w[g], exp_v); end
                checks++; if (out_last[g] !== (no == 7)) begin errors++; $display("FAIL bp_out_last dut%0d beat%0d: got %b want %b", g, no, out_last[g], (no == 7)); end
                no++;
            end
            tick();
            if (acc) ni++;
        end
        in_valid[g] = 1'b0; out_ready[g] = 1'b1; in_last = 1'b0;
        checks++; if (no != 8 || ni != 8) begin errors++; $display("FAIL bp_count dut%0d: got in %0d out %0d want 8 8", g, ni, no); end
        checks++; if (stall_seen !== 1'b1) begin errors++; $display("FAIL bp_stall dut%0d: got %b want 1", g, stall_seen); end
        checks++; if (beat_cnt[g] !== 16'd8) begin errors++; $display("FAIL bp_beat_cnt dut%0d: got %0d want 8", g, beat_cnt[g]); end
    endtask

    task automatic test_b_in_flight();
        int got;
        do_reset();
        load_b(16'h3C00);
        for (int l = 0; l < 16; l++) lane_val[l] = 16'h3C00;
        in_valid[0] = 1'b1;
        tick();
        b_load = 1'b1; b_inp = 16'h4000;
        for (int l = 0; l < 16; l++) lane_val[l] = 16'h4000;
        tick();
        b_load = 1'b0; in_valid[0] = 1'b0;
        checks++; if (beat_cnt[0] !== 16'd1) begin errors++; $display("FAIL bflight_beat_cnt: got %0d want 1", beat_cnt[0]); end
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            if (out_valid[0]) begin
                checks++; if (outp_w[0] !== '0) begin errors++; $display("FAIL bflight_outp beat%0d: got %h want 0", got, outp_w[0]); end
                got++;
            end
            tick();
        end
        checks++; if (got != 2) begin errors++; $display("FAIL bflight_count: got %0d want 2", got); end
    endtask

    task automatic test_nan_last();
        logic [15:0] l2;
        int k;
        do_reset();
        load_b(16'h3C00);
        for (int l = 0; l < 16; l++) lane_val[l] = 16'h4200;
        lane_val[2] = 16'h7E00;
        in_last = 1'b1; in_valid[0] = 1'b1;
        tick();
        in_last = 1'b0; in_valid[0] = 1'b0;
        checks++; if (nan_seen[0] !== 1'b0) begin errors++; $display("FAIL nan_early: got %b want 0", nan_seen[0]); end
        k = 0;
        while (out_valid[0] !== 1'b1 && k < 10) begin tick(); k++; end
        l2 = outp_w[0][32 +: 16];
        checks++; if (!(l2[14:10] == 5'h1F && l2[9:0] != 10'd0)) begin errors++; $display("FAIL nan_lane2: got %h want a NaN", l2); end
        checks++; if (outp_w[0][31:0] !== 32'h40004000 || outp_w[0][63:48] !== 16'h4000) begin errors++; $display("FAIL nan_other_lanes: got %h want lanes 4000", outp_w[0][63:0]); end
        checks++; if (out_last[0] !== 1'b1) begin errors++; $display("FAIL nan_out_last: got %b want 1", out_last[0]); end
        tick();
        checks++; if (nan_seen[0] !== 1'b1) begin errors++; $display("FAIL nan_set: got %b want 1", nan_seen[0]); end
        load_b(16'h3C00);
        checks++; if (nan_seen[0] !== 1'b0) begin errors++; $display("FAIL nan_clear: got %b want 0", nan_seen[0]); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [MAXW-1:0] exp_v;
        int k;
        do_reset();
        load_b(16'h3C00);
        for (int l = 0; l < 16; l++) lane_val[l] = 16'h4200;
        in_valid[0] = 1'b1;
        tick();
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rmid_pre: got %b want 0", out_valid[0]); end
        reset = 1'b1; b_load = 1'b1; b_inp = 16'h4000;
        tick();
        reset = 1'b0; b_load = 1'b0; in_valid[0] = 1'b0;
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid[0]); end
        checks++; if (out_last[0] !== 1'b0) begin errors++; $display("FAIL rmid_out_last: got %b want 0", out_last[0]); end
        checks++; if (beat_cnt[0] !== 16'd0) begin errors++; $display("FAIL rmid_beat_cnt: got %0d want 0", beat_cnt[0]); end
        checks++; if (nan_seen[0] !== 1'b0) begin errors++; $display("FAIL rmid_nan_seen: got %b want 0", nan_seen[0]); end
        checks++; if (outp_w[0] !== '0) begin errors++; $display("FAIL rmid_outp: got %h want 0", outp_w[0]); end
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready[0]); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid[0]) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_ghost: got %b want 0", seen); end
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        k = 0;
        while (out_valid[0] !== 1'b1 && k < 10) begin tick(); k++; end
        exp_v = '0;
        for (int l = 0; l < 4; l++) exp_v[l*16 +: 16] = 16'h4200;
        checks++; if (outp_w[0] !== exp_v) begin errors++; $display("FAIL rmid_b_zero: got %h want %h", outp_w[0], exp_v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; b_load = 1'b0; b_inp = '0; in_last = 1'b0;
        in_valid = '0; out_ready = '1;
        for (int l = 0; l < 16; l++) lane_val[l] = '0;
        for (int g = 0; g < NI; g++) begin
            test_reset(g);
            test_basic(g);
            test_backpressure(g);
        end
        test_b_in_flight();
        test_nan_last();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mode6_sub_pipe.md
MODE6_SUB_PIPE -- requirements
Module: mode6_sub_pipe

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, meaning the number of parallel subtract lanes (legal range 1..16).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from input accept to output valid (legal range 1..4).
REQ-003 SHALL take DATAWIDTH, MANTISSA, EXPONENT and IEEE_COMPLIANCE from defines.v (16-bit half precision: 10, 5, 0).
REQ-004 SHALL have one clock and a synchronous, active-high reset; the clock and reset ports are named clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 b_load  input  1  capture b_inp into the subtrahend register.
REQ-008 b_inp  input  DATAWIDTH  subtrahend (running maximum).
REQ-009 in_valid  input  1  an input beat is present.
REQ-010 in_ready  output  1  the block can accept a beat.
REQ-011 in_last  input  1  this beat is the final beat of the row.
REQ-012 a_inp  input  NUM_LANES*DATAWIDTH  packed minuends; lane i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-013 out_valid  output  1  an output beat is present.
REQ-014 out_ready  input  1  the downstream block accepts the beat.
REQ-015 outp  output  NUM_LANES*DATAWIDTH  packed results, lane i = a_inp lane i minus b.
REQ-016 out_last  output  1  in_last carried alongside the beat.
REQ-017 beat_cnt  output  16  count of beats accepted since the last b_load or reset.
REQ-018 nan_seen  output  1  sticky flag: some emitted lane was NaN.

Function
REQ-019 An input beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1; an output beat SHALL be consumed only in a cycle where out_valid and out_ready are both 1.
REQ-020 Each lane SHALL compute a DW_fp_sub with rnd=3'b000 (round to nearest even), one instance per lane.
REQ-021 The pipeline SHALL consist of LATENCY register stages, each holding a valid bit, the lane data, a b snapshot and a last bit.
REQ-022 The subtraction SHALL be evaluated between stage 1 and stage 2; when LATENCY=1 it SHALL be evaluated before the single stage.
REQ-023 The pipeline SHALL stall globally: advance = out_ready OR NOT out_valid, and in_ready = advance.
REQ-024 When not stalled, a beat accepted in cycle N SHALL appear on outp with out_valid=1 in cycle N+LATENCY.
REQ-025 When stalled, all stages, outp and out_last SHALL hold their values.
REQ-026 Bubbles (in_valid=0 while advancing) SHALL propagate as valid=0 stages and SHALL NOT stall the pipeline.
REQ-027 b_reg SHALL update on any cycle with b_load=1, regardless of stall.
REQ-028 Each accepted beat SHALL snapshot b_reg at acceptance; if b_load and the accept occur in the same cycle, the beat SHALL use the new b_inp.
REQ-029 A b_load SHALL NOT alter beats already in flight.
REQ-030 beat_cnt SHALL increment by 1 on each accept and SHALL saturate at 16'hFFFF.
REQ-031 b_load SHALL set beat_cnt to 0, or to 1 if an accept occurs in the same cycle.
REQ-032 nan_seen SHALL set when an emitted beat (out_valid and out_ready) has any lane with exponent all ones and a nonzero mantissa.
REQ-033 nan_seen SHALL clear on b_load; if a NaN is emitted in the same cycle as b_load, setting wins.
REQ-034 out_last SHALL equal the last bit of the beat currently on outp.

Reset
REQ-035 While reset=1 at a clock edge, all stage valid bits, out_valid, out_last, beat_cnt and nan_seen SHALL go to 0, and b_reg and outp SHALL go to all zeros.
REQ-036 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-037 Reset SHALL take priority over b_load and over any in-flight or simultaneous accept; in-flight beats SHALL be discarded and never emitted.

Verification
REQ-038 Basic subtract: reset, then b_load with b_inp=16'h3C00 (1.0), then one beat with all lanes 16'h4200 (3.0) and out_ready=1 -> LATENCY cycles later out_valid=1, every lane 16'h4000, beat_cnt=1.
REQ-039 Back-pressure: stream 8 beats with out_ready held 0 for 5 cycles mid-stream -> no beat lost or duplicated, order preserved, in_ready=0 exactly while out_valid=1 and out_ready=0.
REQ-040 b change in flight: b=16'h3C00, accept beat A=16'h3C00, next cycle b_load with 16'h4000 and accept beat B=16'h4000 -> A emits 16'h0000, B emits 16'h0000, beat_cnt=1.
REQ-041 NaN and last: lane 2 = 16'h7E00 with in_last=1 -> output lane 2 is NaN, out_last=1, nan_seen=1 after the emit, and nan_seen=0 after the next b_load.
REQ-042 Reset mid-operation: reset asserted for 1 cycle with LATENCY beats in flight -> no out_valid for those beats, and all outputs at their reset values per REQ-035.
REQ-043 Parameter sweep: repeat REQ-038 and REQ-039 at NUM_LANES=1,4,16 and LATENCY=1,4 -> latency and packing match REQ-012 and REQ-024.
